// File: rtl/word_weight_acc.sv
// word_weight_acc
//   Computes a per-word value from N 2-bit digits and sums those values over
//   blocks of words delimited by in_last. It emits one result per block:
//   the saturating sum, the saturating word count, and a saturation flag.
//   Stage 1 registers the per-word value. Stage 2 accumulates it and, on the
//   last word of a block, loads the output registers.
//   The block's mode and sel_base are sampled from its first word.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   word_in / in_last / mode / sel_base are valid
//   in_ready   a word is accepted this cycle (!out_valid || out_ready)
//   word_in    N digits, digit i = word_in[2i+1:2i]
//   in_last    word is the final word of its block
//   mode       00 digit sum, 01 count of digits == sel_base,
//              10 GC count (digit 01 or 10), 11 same as 00
//   sel_base   digit value matched in mode 01
//   out_valid  block result available
//   out_ready  consumer takes the result
//   out_sum    block accumulated value (saturating)
//   out_count  words in block (saturating)
//   out_sat    accumulator or counter saturated during the block
module word_weight_acc #(
   parameter int N     = 4,
   parameter int SUM_W = 10,
   parameter int ACC_W = 16,
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2*N-1:0]     word_in,
   input  logic               in_last,
   input  logic [1:0]         mode,
   input  logic [1:0]         sel_base,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ACC_W-1:0]   out_sum,
   output logic [CNT_W-1:0]   out_count,
   output logic               out_sat
);

   typedef enum logic {IDLE, ACCUM} state_t;

   // Wide enough to hold the sum of the accumulator and one word value.
   localparam int EW = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;

   function automatic logic [SUM_W-1:0] word_value(input logic [2*N-1:0] w,
                                                   input logic [1:0] md,
                                                   input logic [1:0] sb);
      logic [SUM_W-1:0] v;
      logic [1:0]       d;
      v = '0;
      for (int i = 0; i < N; i++) begin
         d = w[2*i +: 2];
         case (md)
            2'b01:   v = v + ((d == sb) ? SUM_W'(1) : SUM_W'(0));
            2'b10:   v = v + ((d == 2'b01 || d == 2'b10) ? SUM_W'(1) : SUM_W'(0));
            default: v = v + SUM_W'(d);
         endcase
      end
      return v;
   endfunction

   // Returns {overflow, saturated sum}.
   function automatic logic [ACC_W:0] sat_acc(input logic [ACC_W-1:0] a,
                                              input logic [SUM_W-1:0] v);
      logic [EW-1:0] s;
      s = EW'(a) + EW'(v);
      if (s > EW'({ACC_W{1'b1}}))
         return {1'b1, {ACC_W{1'b1}}};
      return {1'b0, s[ACC_W-1:0]};
   endfunction

   // Returns {overflow, saturated count + 1}.
   function automatic logic [CNT_W:0] sat_cnt(input logic [CNT_W-1:0] c);
      if (c == {CNT_W{1'b1}})
         return {1'b1, c};
      return {1'b0, c + CNT_W'(1)};
   endfunction

   state_t             state_q, state_d;
   logic [1:0]         mode_blk_q, mode_blk_d;
   logic [1:0]         sel_blk_q, sel_blk_d;
   logic [SUM_W-1:0]   val_p1_q, val_p1_d;
   logic               vld_p1_q, vld_p1_d;
   logic               last_p1_q, last_p1_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               sat_q, sat_d;
   logic               out_valid_q, out_valid_d;
   logic [ACC_W-1:0]   out_sum_q, out_sum_d;
   logic [CNT_W-1:0]   out_count_q, out_count_d;
   logic               out_sat_q, out_sat_d;

   logic               ready;
   logic               accept;
   logic [1:0]         eff_mode;
   logic [1:0]         eff_sel;
   logic [ACC_W:0]     acc_r;
   logic [CNT_W:0]     cnt_r;
   logic               blk_sat;

   // A pending result that is not being taken stalls the whole pipeline.
   assign ready    = !out_valid_q || out_ready;
   assign accept   = in_valid && ready;
   // The first word of a block uses the live mode inputs; later words use the latched ones.
   assign eff_mode = (state_q == IDLE) ? mode     : mode_blk_q;
   assign eff_sel  = (state_q == IDLE) ? sel_base : sel_blk_q;

   always_comb begin
      state_d     = state_q;
      mode_blk_d  = mode_blk_q;
      sel_blk_d   = sel_blk_q;
      val_p1_d    = val_p1_q;
      vld_p1_d    = vld_p1_q;
      last_p1_d   = last_p1_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      sat_d       = sat_q;
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_count_d = out_count_q;
      out_sat_d   = out_sat_q;
      acc_r       = '0;
      cnt_r       = '0;
      blk_sat     = 1'b0;

      // block framing
      if (accept) begin
         if (state_q == IDLE) begin
            mode_blk_d = mode;
            sel_blk_d  = sel_base;
            state_d    = in_last ? IDLE : ACCUM;
         end else if (in_last) begin
            state_d = IDLE;
         end
      end

      // stage 1: per-word value
      if (ready) begin
         vld_p1_d = in_valid;
         if (in_valid) begin
            val_p1_d  = word_value(word_in, eff_mode, eff_sel);
            last_p1_d = in_last;
         end
      end

      // output handshake; a result loaded below on the same edge overrides this
      if (out_valid_q && out_ready)
         out_valid_d = 1'b0;

      // stage 2: accumulate, and publish on the last word of a block
      if (ready && vld_p1_q) begin
         acc_r   = sat_acc(acc_q, val_p1_q);
         cnt_r   = sat_cnt(cnt_q);
         blk_sat = sat_q | acc_r[ACC_W] | cnt_r[CNT_W];
         if (last_p1_q) begin
            out_valid_d = 1'b1;
            out_sum_d   = acc_r[ACC_W-1:0];
            out_count_d = cnt_r[CNT_W-1:0];
            out_sat_d   = blk_sat;
            acc_d       = '0;
            cnt_d       = '0;
            sat_d       = 1'b0;
         end else begin
            acc_d = acc_r[ACC_W-1:0];
            cnt_d = cnt_r[CNT_W-1:0];
            sat_d = blk_sat;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         mode_blk_q  <= 2'b00;
         sel_blk_q   <= 2'b00;
         val_p1_q    <= '0;
         vld_p1_q    <= 1'b0;
         last_p1_q   <= 1'b0;
         acc_q       <= '0;
         cnt_q       <= '0;
         sat_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_count_q <= '0;
         out_sat_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_blk_q  <= mode_blk_d;
         sel_blk_q   <= sel_blk_d;
         val_p1_q    <= val_p1_d;
         vld_p1_q    <= vld_p1_d;
         last_p1_q   <= last_p1_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         sat_q       <= sat_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_count_q <= out_count_d;
         out_sat_q   <= out_sat_d;
      end
   end

   assign in_ready  = ready;
   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_count = out_count_q;
   assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_word_weight_acc.sv
// Bench for word_weight_acc: two instances share one input stream, one with
// default widths and one with ACC_W=4 / CNT_W=3 to reach saturation quickly.
// A block-level reference model predicts every result.
module tb_word_weight_acc;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid, in_last, out_ready;
   logic [7:0]  word_in;
   logic [1:0]  mode, sel_base;

   logic        in_ready, out_valid, out_sat;
   logic [15:0] out_sum;
   logic [7:0]  out_count;

   logic        s_in_ready, s_out_valid, s_out_sat;
   logic [3:0]  s_out_sum;
   logic [2:0]  s_out_count;

   word_weight_acc #(.N(N), .SUM_W(10), .ACC_W(16), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .word_in(word_in), .in_last(in_last), .mode(mode), .sel_base(sel_base),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_count(out_count), .out_sat(out_sat)
   );

   word_weight_acc #(.N(N), .SUM_W(10), .ACC_W(4), .CNT_W(3)) dut_s (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
      .word_in(word_in), .in_last(in_last), .mode(mode), .sel_base(sel_base),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_sum(s_out_sum),
      .out_count(s_out_count), .out_sat(s_out_sat)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // ---------------- reference model (block level) ----------------
   typedef struct {
      int s16; int c16; bit t16;
      int s4;  int c4;  bit t4;
   } exp_t;

   exp_t exq[$];
   bit   m_open = 0;
   int   m_mode, m_sel;
   int   m_sum = 0;
   int   m_cnt = 0;

   function automatic int wval(input int w, input int md, input int sb);
      int v = 0;
      int d;
      for (int i = 0; i < N; i++) begin
         d = (w >> (2*i)) & 3;
         if (md == 1)      v += (d == sb) ? 1 : 0;
         else if (md == 2) v += (d == 1 || d == 2) ? 1 : 0;
         else              v += d;
      end
      return v;
   endfunction

   task automatic model_accept(input int w, input bit last, input int md, input int sb);
      exp_t e;
      if (!m_open) begin
         m_mode = md;
         m_sel  = sb;
      end
      m_sum += wval(w, m_mode, m_sel);
      m_cnt++;
      if (last) begin
         e.s16 = (m_sum > 65535) ? 65535 : m_sum;
         e.c16 = (m_cnt > 255) ? 255 : m_cnt;
         e.t16 = (m_sum > 65535) || (m_cnt > 255);
         e.s4  = (m_sum > 15) ? 15 : m_sum;
         e.c4  = (m_cnt > 7) ? 7 : m_cnt;
         e.t4  = (m_sum > 15) || (m_cnt > 7);
         exq.push_back(e);
         m_open = 0;
         m_sum  = 0;
         m_cnt  = 0;
      end else begin
         m_open = 1;
      end
   endtask

   // ---------------- monitor (samples on falling edge) ----------------
   int          last_s16, last_c16, last_s4, last_c4;
   bit          last_t16, last_t4;
   bit          stall_prev = 0;
   int          stall_seen = 0;
   logic [15:0] h_sum;
   logic [7:0]  h_cnt;
   logic        h_sat;

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         stall_prev = 0;
      end else begin
         if (stall_prev) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_sum", out_sum, h_sum);
            chk("hold_count", out_count, h_cnt);
            chk("hold_sat", out_sat, h_sat);
         end
         if (out_valid && !out_ready) begin
            chk("stall_in_ready", in_ready, 0);
            stall_seen++;
         end
         if (out_valid && out_ready) begin
            if (exq.size() == 0) begin
               chk("spurious_result", 1, 0);
            end else begin
               e = exq.pop_front();
               chk("sum16", out_sum, e.s16);
               chk("count16", out_count, e.c16);
               chk("sat16", out_sat, e.t16);
               chk("valid4", s_out_valid, 1);
               chk("sum4", s_out_sum, e.s4);
               chk("count4", s_out_count, e.c4);
               chk("sat4", s_out_sat, e.t4);
               last_s16 = out_sum;   last_c16 = out_count;   last_t16 = out_sat;
               last_s4  = s_out_sum; last_c4  = s_out_count; last_t4  = s_out_sat;
            end
         end
         stall_prev = out_valid && !out_ready;
         h_sum = out_sum;
         h_cnt = out_count;
         h_sat = out_sat;
         if (in_valid && in_ready)
            model_accept(word_in, in_last, mode, sel_base);
      end
   end

   // ---------------- driver ----------------
   bit rnd_rdy = 0;

   task automatic send(input logic [7:0] w, input bit last, input logic [1:0] md,
                       input logic [1:0] sb);
      int n = 0;
      in_valid = 1'b1;
      word_in  = w;
      in_last  = last;
      mode     = md;
      sel_base = sb;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(posedge clk); #1;
         if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("accept_timeout", 0, 1);
      @(posedge clk); #1;
      if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic idle1();
      in_valid = 1'b0;
      @(posedge clk); #1;
      if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("drain_empty", exq.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int len;
      in_valid = 1'b0; in_last = 1'b0; word_in = '0;
      mode = 2'b00; sel_base = 2'b00; out_ready = 1'b1;

      // reset state
      #1 rst = 1'b1;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_sum", out_sum, 0);
      chk("rst_out_count", out_count, 0);
      chk("rst_out_sat", out_sat, 0);
      chk("rst_in_ready", in_ready, 1);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("post_rst_in_ready", in_ready, 1);

      // single-word digit sum and latency
      send(8'b11_10_01_00, 1, 2'b00, 2'b00);
      in_valid = 1'b0;
      chk("r037_valid_edge_k", out_valid, 0);
      @(posedge clk); #1;
      chk("r037_valid_edge_k1", out_valid, 1);
      drain();
      chk("r037_sum", last_s16, 6);
      chk("r037_count", last_c16, 1);
      chk("r037_sat", last_t16, 0);

      // GC count, mode toggled mid-block
      send(8'hFF, 0, 2'b10, 2'b00);
      send(8'h66, 0, 2'b00, 2'b11);
      send(8'h1B, 1, 2'b01, 2'b01);
      drain();
      chk("r038_sum", last_s16, 6);
      chk("r038_count", last_c16, 3);

      // count digits equal to 3
      send(8'hFF, 0, 2'b01, 2'b11);
      send(8'hC0, 1, 2'b10, 2'b00);
      drain();
      chk("r039_sum", last_s16, 5);
      chk("r039_count", last_c16, 2);

      // accumulator saturation, then clean next block
      for (int i = 0; i < 5; i++) send(8'hFF, (i == 4), 2'b00, 2'b00);
      drain();
      chk("r040_sum4", last_s4, 15);
      chk("r040_sat4", last_t4, 1);
      chk("r040_sum16", last_s16, 60);
      send(8'h01, 1, 2'b00, 2'b00);
      drain();
      chk("r040_next_sum4", last_s4, 1);
      chk("r040_next_sat4", last_t4, 0);

      // output back-pressure while inputs keep streaming
      stall_seen = 0;
      out_ready  = 1'b0;
      fork
         begin
            send(8'h55, 0, 2'b00, 2'b00);
            send(8'h0F, 1, 2'b00, 2'b00);
            for (int i = 0; i < 5; i++) send(8'h12, (i == 4), 2'b00, 2'b00);
            in_valid = 1'b0;
         end
         begin
            repeat (8) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      chk("r041_stall_cycles", (stall_seen >= 5) ? 1 : 0, 1);
      chk("r041_sum", last_s16, 15);
      chk("r041_count", last_c16, 5);

      // reset in the middle of a block
      send(8'h3F, 0, 2'b00, 2'b00);
      send(8'h3F, 0, 2'b00, 2'b00);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("r042_rst_valid", out_valid, 0);
      chk("r042_rst_in_ready", in_ready, 1);
      m_open = 0; m_sum = 0; m_cnt = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("r042_no_partial", out_valid, 0);
      end
      send(8'h03, 1, 2'b00, 2'b00);
      drain();
      chk("r042_sum", last_s16, 3);
      chk("r042_count", last_c16, 1);

      // randomized blocks with random back-pressure and gaps
      rnd_rdy = 1;
      for (int b = 0; b < 150; b++) begin
         len = $urandom_range(1, 10);
         for (int w = 0; w < len; w++) begin
            if ($urandom_range(0, 3) == 0) idle1();
            send(8'($urandom), (w == len - 1), 2'($urandom), 2'($urandom));
         end
      end
      in_valid = 1'b0;
      rnd_rdy  = 0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/word_weight_acc.md
WORD_WEIGHT_ACC -- requirements
Module: word_weight_acc

Interface
REQ-001 Parameter: N, default 4, number of 2-bit digits per word (1..99).
REQ-002 Parameter: SUM_W, default 10, width of per-word value; SHALL hold 3*N.
REQ-003 Parameter: ACC_W, default 16, block accumulator width.
REQ-004 Parameter: CNT_W, default 8, block word-count width.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 Port: clk  in  1  rising-edge clock.
REQ-007 Port: rst  in  1  asynchronous active-high reset.
REQ-008 Port: in_valid  in  1  word_in/in_last/mode/sel_base valid.
REQ-009 Port: in_ready  out  1  block accepts a word this cycle.
REQ-010 Port: word_in  in  2*N  N digits; digit i = word_in[2i+1:2i].
REQ-011 Port: in_last  in  1  word is final word of its block.
REQ-012 Port: mode  in  2  00 digit sum, 01 count digits == sel_base, 10 GC count (digit 01 or 10), 11 reserved (treated as 00).
REQ-013 Port: sel_base  in  2  digit value compared in mode 01.
REQ-014 Port: out_valid  out  1  block result available.
REQ-015 Port: out_ready  in  1  consumer takes result.
REQ-016 Port: out_sum  out  ACC_W  block accumulated value.
REQ-017 Port: out_count  out  CNT_W  words in block (saturating).
REQ-018 Port: out_sat  out  1  accumulator or counter saturated during block.

Function
REQ-019 Transfer in when in_valid && in_ready; out when out_valid && out_ready.
REQ-020 in_ready SHALL be !out_valid || out_ready (combinational, global stall).
REQ-021 Stage 1: on accepted word, register s1_val = per-word value per the block's mode, s1_valid=1, s1_last=in_last; s1_valid=0 on edges with no transfer and no stall.
REQ-022 While stalled (in_ready=0) s1 and the accumulator SHALL hold.
REQ-023 Stage 2: each non-stalled edge with s1_valid adds s1_val to acc and increments count.
REQ-024 FSM states IDLE (no block open) and ACCUM (block open); reset state IDLE.
REQ-025 IDLE: accepted word latches mode and sel_base for the block; goes to ACCUM unless in_last (stays IDLE).
REQ-026 ACCUM: mode/sel_base inputs ignored; accepted word with in_last -> IDLE.
REQ-027 Word with in_last accepted at edge k: out_valid=1 after edge k+1 with out_sum = block total, out_count, out_sat.
REQ-028 At the stage-2 edge that completes a block, acc, count and sat SHALL clear so the next block starts at zero.
REQ-029 Outputs SHALL hold stable while out_valid && !out_ready.
REQ-030 out_valid clears on out transfer unless a new result loads the same edge (then stays 1 with new values).
REQ-031 Back-to-back blocks, including one-word blocks, SHALL sustain one word per cycle when out_ready=1.
REQ-032 acc SHALL saturate at 2^ACC_W-1; count at 2^CNT_W-1; either sets out_sat for that block.
REQ-033 Per-word arithmetic SHALL be unsigned, zero-extended to SUM_W, no overflow for legal N.

Reset
REQ-034 rst=1 SHALL immediately force: out_valid=0, out_sum=0, out_count=0, out_sat=0, acc=0, count=0, s1_valid=0, state IDLE.
REQ-035 A block in progress at reset SHALL be discarded; no partial result emitted.
REQ-036 in_ready SHALL be 1 during and after reset.

Verification
REQ-037 N=4, mode 00, single word 8'b11_10_01_00 in_last=1 -> out_sum=6, out_count=1, out_sat=0, out_valid 2 edges after accept.
REQ-038 Mode 10, block of 3 words 8'hFF, 8'h66, 8'h1B -> per-word 0,4,2 -> out_sum=6, out_count=3; mode toggled mid-block has no effect.
REQ-039 Mode 01 sel_base=2'b11, words 8'hFF, 8'hC0 -> out_sum=5, out_count=2.
REQ-040 ACC_W=4, mode 00, five words 8'hFF -> out_sum=15, out_sat=1; next block 8'h01 -> out_sum=1, out_sat=0.
REQ-041 out_ready=0 for 5 cycles with result pending and inputs streaming -> in_ready=0, outputs stable, no word lost; release yields correct next block.
REQ-042 rst pulsed after 2 words of a 4-word block -> out_valid stays 0; next 1-word block 8'h03 mode 00 -> out_sum=3, out_count=1.
